// File: rtl/sram_resp_pkg.sv
// Shared types for the SRAM responder: FSM state encoding and the registered ram_* pin group.
package sram_resp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } state_t;

   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] dq_o;
      logic        dq_oe;
      logic        ce_n;
      logic        oe_n;
      logic        we_n;
      logic        ub_n;
      logic        lb_n;
   } SramPins;

   localparam SramPins PINS_RST = '{
      addr:  '0,
      dq_o:  '0,
      dq_oe: 1'b0,
      ce_n:  1'b1,
      oe_n:  1'b1,
      we_n:  1'b1,
      ub_n:  1'b1,
      lb_n:  1'b1
   };

endpackage

// File: rtl/sram_resp_if.sv
// CPU port, DMA port and SRAM pin bundle; slave is the responder, master is its environment.
interface sram_resp_if;
   logic        cpu_req;
   logic        cpu_oe;
   logic        cpu_we;
   logic [22:0] cpu_addr;
   logic [7:0]  cpu_dati;
   logic [7:0]  cpu_dato;
   logic        cpu_ack;

   logic        dma_req;
   logic        dma_oe;
   logic        dma_we;
   logic [22:0] dma_addr;
   logic [15:0] dma_dati;
   logic [15:0] dma_dato;
   logic        dma_ack;

   logic [21:0] ram_addr;
   logic [15:0] ram_dq_o;
   logic        ram_dq_oe;
   logic [15:0] ram_dq_i;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;
   logic        ram_ub_n;
   logic        ram_lb_n;

   modport slave (
      input  cpu_req, cpu_oe, cpu_we, cpu_addr, cpu_dati,
      output cpu_dato, cpu_ack,
      input  dma_req, dma_oe, dma_we, dma_addr, dma_dati,
      output dma_dato, dma_ack,
      output ram_addr, ram_dq_o, ram_dq_oe,
      input  ram_dq_i,
      output ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n
   );

   modport master (
      output cpu_req, cpu_oe, cpu_we, cpu_addr, cpu_dati,
      input  cpu_dato, cpu_ack,
      output dma_req, dma_oe, dma_we, dma_addr, dma_dati,
      input  dma_dato, dma_ack,
      input  ram_addr, ram_dq_o, ram_dq_oe,
      output ram_dq_i,
      input  ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n
   );
endinterface

// File: rtl/sram_resp_req_trk.sv
// Per-port request tracker: one raised request per assertion of req with a strobe.
module req_trk (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic oe,
   input  logic we,
   input  logic ack,
   output logic raise
);
   logic active;
   logic serviced_q, serviced_d;

   // Deassertion wins over ack so a port that dropped mid-access is left clear.
   always_comb begin
      active     = req & (oe | we);
      serviced_d = serviced_q;
      if (!active)
         serviced_d = 1'b0;
      else if (ack)
         serviced_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         serviced_q <= 1'b0;
      else
         serviced_q <= serviced_d;
   end

   assign raise = active & ~serviced_q;
endmodule

// File: rtl/sram_resp.sv
// Two-port (CPU byte / DMA word) asynchronous SRAM responder with fixed-phase strobe timing.
module sram_resp
   import sram_resp_pkg::*;
#(
   parameter int unsigned WAIT_CYC = 3
) (
   input  logic        clk,
   input  logic        rst,
   sram_resp_if.slave  bus
);
   localparam logic [3:0] LAST = 4'(WAIT_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   SramPins     pins_q, pins_d;
   logic        sel_dma_q, sel_dma_d;
   logic        wr_q, wr_d;
   logic        byte_q, byte_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic [7:0]  cpu_dato_q, cpu_dato_d;
   logic [15:0] dma_dato_q, dma_dato_d;
   logic        cpu_raise, dma_raise;

   req_trk u_cpu_trk (
      .clk   (clk),
      .rst   (rst),
      .req   (bus.cpu_req),
      .oe    (bus.cpu_oe),
      .we    (bus.cpu_we),
      .ack   (cpu_ack_q),
      .raise (cpu_raise)
   );

   req_trk u_dma_trk (
      .clk   (clk),
      .rst   (rst),
      .req   (bus.dma_req),
      .oe    (bus.dma_oe),
      .we    (bus.dma_we),
      .ack   (dma_ack_q),
      .raise (dma_raise)
   );

   // Pins are registered, so each branch sets up what the next state drives.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pins_d     = pins_q;
      sel_dma_d  = sel_dma_q;
      wr_d       = wr_q;
      byte_d     = byte_q;
      cpu_ack_d  = 1'b0;
      dma_ack_d  = 1'b0;
      cpu_dato_d = cpu_dato_q;
      dma_dato_d = dma_dato_q;

      case (state_q)
         IDLE: begin
            if (cpu_raise || dma_raise) begin
               state_d   = SETUP;
               sel_dma_d = ~cpu_raise;
               if (cpu_raise) begin
                  wr_d        = bus.cpu_we;
                  byte_d      = bus.cpu_addr[0];
                  pins_d.addr = bus.cpu_addr[22:1];
                  pins_d.dq_o = {2{bus.cpu_dati}};
                  pins_d.ub_n = bus.cpu_we & ~bus.cpu_addr[0];
                  pins_d.lb_n = bus.cpu_we & bus.cpu_addr[0];
               end else begin
                  wr_d        = bus.dma_we;
                  byte_d      = 1'b0;
                  pins_d.addr = bus.dma_addr[22:1];
                  pins_d.dq_o = bus.dma_dati;
                  pins_d.ub_n = 1'b0;
                  pins_d.lb_n = 1'b0;
               end
               pins_d.ce_n  = 1'b0;
               pins_d.oe_n  = 1'b1;
               pins_d.we_n  = 1'b1;
               pins_d.dq_oe = wr_d;
            end
         end
         SETUP: begin
            state_d     = ACCESS;
            cnt_d       = '0;
            pins_d.oe_n = wr_q;
            pins_d.we_n = ~wr_q;
         end
         ACCESS: begin
            if (cnt_q == LAST) begin
               state_d     = HOLD;
               cnt_d       = '0;
               pins_d.oe_n = 1'b1;
               pins_d.we_n = 1'b1;
               if (sel_dma_q)
                  dma_ack_d = 1'b1;
               else
                  cpu_ack_d = 1'b1;
               if (!wr_q) begin
                  if (sel_dma_q)
                     dma_dato_d = bus.ram_dq_i;
                  else
                     cpu_dato_d = byte_q ? bus.ram_dq_i[15:8] : bus.ram_dq_i[7:0];
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD: begin
            state_d      = IDLE;
            pins_d.ce_n  = 1'b1;
            pins_d.ub_n  = 1'b1;
            pins_d.lb_n  = 1'b1;
            pins_d.dq_oe = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pins_q     <= PINS_RST;
         sel_dma_q  <= 1'b0;
         wr_q       <= 1'b0;
         byte_q     <= 1'b0;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         cpu_dato_q <= '0;
         dma_dato_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pins_q     <= pins_d;
         sel_dma_q  <= sel_dma_d;
         wr_q       <= wr_d;
         byte_q     <= byte_d;
         cpu_ack_q  <= cpu_ack_d;
         dma_ack_q  <= dma_ack_d;
         cpu_dato_q <= cpu_dato_d;
         dma_dato_q <= dma_dato_d;
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_dato  = cpu_dato_q;
   assign bus.dma_dato  = dma_dato_q;
   assign bus.ram_addr  = pins_q.addr;
   assign bus.ram_dq_o  = pins_q.dq_o;
   assign bus.ram_dq_oe = pins_q.dq_oe;
   assign bus.ram_ce_n  = pins_q.ce_n;
   assign bus.ram_oe_n  = pins_q.oe_n;
   assign bus.ram_we_n  = pins_q.we_n;
   assign bus.ram_ub_n  = pins_q.ub_n;
   assign bus.ram_lb_n  = pins_q.lb_n;
endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: behavioural SRAM plus a word-array reference model of expected contents and timing.
`timescale 1ns/1ps
module tb_sram_resp;
   localparam int unsigned W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   sram_resp_if bus();
   sram_resp_if bus1();
   sram_resp_if bus15();

   sram_resp #(.WAIT_CYC(W))  dut   (.clk(clk), .rst(rst), .bus(bus));
   sram_resp #(.WAIT_CYC(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
   sram_resp #(.WAIT_CYC(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

   function automatic logic [15:0] init_val(input logic [9:0] i);
      return {i[7:0] ^ 8'hC3, ~i[9:2]};
   endfunction

   function automatic logic [15:0] pat(input logic [21:0] a);
      return {~a[7:0], a[7:0] ^ 8'h5A};
   endfunction

   // Behavioural SRAM on the main bus; unwritten words read back as init_val.
   logic [15:0] sram [1024];
   bit          written [1024];
   logic [9:0]  widx;
   logic [15:0] cur;
   assign widx = bus.ram_addr[9:0];
   assign bus.ram_dq_i = (!bus.ram_ce_n && !bus.ram_oe_n)
                         ? (written[widx] ? sram[widx] : init_val(widx)) : 16'h0BAD;

   always @(posedge clk) begin
      if (!bus.ram_ce_n && !bus.ram_we_n && bus.ram_dq_oe) begin
         cur = written[widx] ? sram[widx] : init_val(widx);
         if (!bus.ram_lb_n) cur[7:0]  = bus.ram_dq_o[7:0];
         if (!bus.ram_ub_n) cur[15:8] = bus.ram_dq_o[15:8];
         sram[widx]    <= cur;
         written[widx] <= 1'b1;
      end
   end

   assign bus1.ram_dq_i  = (!bus1.ram_ce_n && !bus1.ram_oe_n) ? pat(bus1.ram_addr) : 16'h0BAD;
   assign bus15.ram_dq_i = (!bus15.ram_ce_n && !bus15.ram_oe_n) ? pat(bus15.ram_addr) : 16'h0BAD;

   always @(negedge clk) begin
      if (!bus.ram_oe_n) begin
         vectors++;
         if (bus.ram_dq_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_contention: dq_oe=%b while oe_n=0, required 0", bus.ram_dq_oe);
         end
      end
   end

   logic [15:0] ref_mem [1024];

   typedef struct {
      int          lat;
      int          we_lo;
      int          oe_lo;
      logic [15:0] rd;
      logic [21:0] addr;
      logic [15:0] dq_o;
      logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
      logic        hold_ce_n, hold_oe_n, hold_we_n;
   } obs_t;

   task automatic idle_inputs(input bit dma);
      if (dma) begin
         bus.dma_req = 1'b0; bus.dma_oe = 1'b0; bus.dma_we = 1'b0;
      end else begin
         bus.cpu_req = 1'b0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0;
      end
   endtask

   // Drives one access from an IDLE cycle and records what the pins and port did; no checking here.
   task automatic run_access(input bit dma, input bit oe, input bit we, input logic [22:0] addr,
                             input logic [15:0] d, output obs_t o);
      o.lat = -1; o.we_lo = 0; o.oe_lo = 0; o.rd = '0; o.addr = '0; o.dq_o = '0;
      o.dq_oe = 1'b0; o.ce_n = 1'b1; o.oe_n = 1'b1; o.we_n = 1'b1; o.ub_n = 1'b1; o.lb_n = 1'b1;
      o.hold_ce_n = 1'b1; o.hold_oe_n = 1'b0; o.hold_we_n = 1'b0;
      if (dma) begin
         bus.dma_req = 1'b1; bus.dma_oe = oe; bus.dma_we = we; bus.dma_addr = addr; bus.dma_dati = d;
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_oe = oe; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_dati = d[7:0];
      end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            o.addr = bus.ram_addr; o.dq_o = bus.ram_dq_o; o.dq_oe = bus.ram_dq_oe; o.ce_n = bus.ram_ce_n;
            o.oe_n = bus.ram_oe_n; o.we_n = bus.ram_we_n; o.ub_n = bus.ram_ub_n; o.lb_n = bus.ram_lb_n;
         end
         if (!bus.ram_we_n) o.we_lo++;
         if (!bus.ram_oe_n) o.oe_lo++;
         if (dma ? bus.dma_ack : bus.cpu_ack) begin
            o.lat = k;
            o.rd  = dma ? bus.dma_dato : {8'h00, bus.cpu_dato};
            o.hold_ce_n = bus.ram_ce_n; o.hold_oe_n = bus.ram_oe_n; o.hold_we_n = bus.ram_we_n;
            break;
         end
      end
      idle_inputs(dma);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.cpu_req = 0; bus.cpu_oe = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_dati = '0;
      bus.dma_req = 0; bus.dma_oe = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_dati = '0;
      bus1.cpu_req = 0; bus1.cpu_oe = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_dati = '0;
      bus1.dma_req = 0; bus1.dma_oe = 0; bus1.dma_we = 0; bus1.dma_addr = '0; bus1.dma_dati = '0;
      bus15.cpu_req = 0; bus15.cpu_oe = 0; bus15.cpu_we = 0; bus15.cpu_addr = '0; bus15.cpu_dati = '0;
      bus15.dma_req = 0; bus15.dma_oe = 0; bus15.dma_we = 0; bus15.dma_addr = '0; bus15.dma_dati = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n} !== 5'b11111) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b required 11111",
                  {bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n});
      end
      vectors++;
      if ({bus.ram_dq_oe, bus.ram_addr, bus.ram_dq_o} !== 39'h0) begin
         miscompares++;
         $display("FAIL reset_bus: dq_oe=%b addr=%h dq_o=%h required 0/0/0", bus.ram_dq_oe, bus.ram_addr, bus.ram_dq_o);
      end
      vectors++;
      if ({bus.cpu_ack, bus.dma_ack, bus.cpu_dato, bus.dma_dato} !== 26'h0) begin
         miscompares++;
         $display("FAIL reset_port: acks=%b%b cpu_dato=%h dma_dato=%h required 0", bus.cpu_ack, bus.dma_ack,
                  bus.cpu_dato, bus.dma_dato);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // DMA write of BEEF to word 0x80, then the CPU byte read of its upper lane.
   task automatic test_cpu_read();
      obs_t o;
      run_access(1'b1, 1'b0, 1'b1, 23'h000100, 16'hBEEF, o);
      ref_mem[10'h080] = 16'hBEEF;
      vectors++;
      if (o.lat !== 5 || {o.ub_n, o.lb_n} !== 2'b00 || o.dq_o !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL dma_write: lat=%0d lanes=%b dq_o=%h required 5/00/beef", o.lat, {o.ub_n, o.lb_n}, o.dq_o);
      end
      run_access(1'b0, 1'b1, 1'b0, 23'h000101, 16'h0, o);
      vectors++;
      if (o.lat !== int'(W) + 2) begin
         miscompares++; $display("FAIL cpu_read_latency: got %0d required %0d", o.lat, W + 2);
      end
      vectors++;
      if (o.rd[7:0] !== 8'hBE) begin
         miscompares++; $display("FAIL cpu_read_data: got %h required be", o.rd[7:0]);
      end
      vectors++;
      if (o.addr !== 22'h000080 || {o.ub_n, o.lb_n} !== 2'b00) begin
         miscompares++; $display("FAIL cpu_read_pins: addr=%h lanes=%b required 000080/00", o.addr, {o.ub_n, o.lb_n});
      end
      vectors++;
      if ({o.ce_n, o.oe_n, o.we_n, o.dq_oe} !== 4'b0110 || o.oe_lo !== int'(W)) begin
         miscompares++;
         $display("FAIL cpu_read_setup: ce/oe/we/dq_oe=%b oe_lo=%0d required 0110/%0d",
                  {o.ce_n, o.oe_n, o.we_n, o.dq_oe}, o.oe_lo, W);
      end
      vectors++;
      if ({o.hold_ce_n, o.hold_oe_n, o.hold_we_n} !== 3'b011) begin
         miscompares++;
         $display("FAIL hold_strobes: ce/oe/we=%b required 011", {o.hold_ce_n, o.hold_oe_n, o.hold_we_n});
      end
   endtask

   task automatic test_cpu_write();
      obs_t o;
      run_access(1'b0, 1'b0, 1'b1, 23'h000010, 16'h005A, o);
      ref_mem[10'h008][7:0] = 8'h5A;
      vectors++;
      if (o.lat !== 5 || {o.ub_n, o.lb_n} !== 2'b10 || o.we_lo !== 3 || o.oe_lo !== 0) begin
         miscompares++;
         $display("FAIL cpu_write_strobes: lat=%0d ub/lb=%b we_lo=%0d oe_lo=%0d required 5/10/3/0",
                  o.lat, {o.ub_n, o.lb_n}, o.we_lo, o.oe_lo);
      end
      vectors++;
      if (o.dq_o !== 16'h5A5A || o.dq_oe !== 1'b1) begin
         miscompares++; $display("FAIL cpu_write_data: dq_o=%h dq_oe=%b required 5a5a/1", o.dq_o, o.dq_oe);
      end
      run_access(1'b1, 1'b1, 1'b0, 23'h000010, 16'h0, o);
      vectors++;
      if (o.rd !== ref_mem[10'h008]) begin
         miscompares++; $display("FAIL cpu_write_readback: got %h required %h", o.rd, ref_mem[10'h008]);
      end
   endtask

   task automatic test_random();
      obs_t o;
      for (int n = 0; n < 60; n++) begin
         bit dma, oe, we;
         int unsigned kind;
         logic [22:0] addr;
         logic [15:0] d, exp_rd, exp_dq;
         logic [9:0]  w;
         logic [1:0]  exp_lanes;
         dma  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         oe   = (kind != 1);
         we   = (kind != 0);
         addr = 23'($urandom_range(0, 2039));
         d    = 16'($urandom);
         w    = addr[10:1];
         exp_lanes = (dma || !we) ? 2'b00 : (addr[0] ? 2'b01 : 2'b10);
         exp_dq    = dma ? d : {d[7:0], d[7:0]};
         exp_rd    = dma ? ref_mem[w] : {8'h00, addr[0] ? ref_mem[w][15:8] : ref_mem[w][7:0]};
         run_access(dma, oe, we, addr, d, o);
         vectors++;
         if (o.lat !== int'(W) + 2 || o.addr !== {12'h0, w} || {o.ub_n, o.lb_n} !== exp_lanes) begin
            miscompares++;
            $display("FAIL rand_%0d_timing: lat=%0d addr=%h lanes=%b required %0d/%h/%b", n, o.lat, o.addr,
                     {o.ub_n, o.lb_n}, W + 2, w, exp_lanes);
         end
         vectors++;
         if (o.we_lo !== (we ? int'(W) : 0) || o.oe_lo !== (we ? 0 : int'(W))) begin
            miscompares++;
            $display("FAIL rand_%0d_strobes: we_lo=%0d oe_lo=%0d for write=%b", n, o.we_lo, o.oe_lo, we);
         end
         if (we) begin
            vectors++;
            if (o.dq_o !== exp_dq || o.dq_oe !== 1'b1) begin
               miscompares++;
               $display("FAIL rand_%0d_wdata: dq_o=%h dq_oe=%b required %h/1", n, o.dq_o, o.dq_oe, exp_dq);
            end
            if (dma) ref_mem[w] = d;
            else if (addr[0]) ref_mem[w][15:8] = d[7:0];
            else ref_mem[w][7:0] = d[7:0];
         end else begin
            vectors++;
            if (o.rd !== exp_rd) begin
               miscompares++; $display("FAIL rand_%0d_rdata: got %h required %h", n, o.rd, exp_rd);
            end
         end
      end
   endtask

   task automatic test_arbitration();
      obs_t o;
      int tc, td;
      run_access(1'b1, 1'b0, 1'b1, 23'h000200, 16'h1234, o);
      ref_mem[10'h100] = 16'h1234;
      tc = -1; td = -1;
      bus.cpu_req = 1; bus.cpu_oe = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h000101;
      bus.dma_req = 1; bus.dma_oe = 1; bus.dma_we = 0; bus.dma_addr = 23'h000200;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.cpu_ack && tc < 0) begin tc = k; idle_inputs(1'b0); end
         if (bus.dma_ack) begin td = k; idle_inputs(1'b1); break; end
      end
      idle_inputs(1'b0); idle_inputs(1'b1);
      vectors++;
      if (tc !== 5 || td !== tc + 6) begin
         miscompares++; $display("FAIL arbitration_order: cpu_ack@%0d dma_ack@%0d required 5/11", tc, td);
      end
      vectors++;
      if (bus.dma_dato !== 16'h1234 || bus.cpu_dato !== ref_mem[10'h080][15:8]) begin
         miscompares++;
         $display("FAIL arbitration_data: dma=%h cpu=%h required 1234/%h", bus.dma_dato, bus.cpu_dato,
                  ref_mem[10'h080][15:8]);
      end
      @(negedge clk);
   endtask

   task automatic test_held_req();
      int acks, first;
      acks = 0; first = -1;
      bus.cpu_req = 1; bus.cpu_oe = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h000101;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin acks++; if (first < 0) first = k; end
      end
      vectors++;
      if (acks !== 1 || first !== 5) begin
         miscompares++; $display("FAIL held_req_once: acks=%0d first@%0d required 1/5", acks, first);
      end
      bus.cpu_req = 0;
      @(negedge clk);
      bus.cpu_req = 1;
      acks = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) acks++;
      end
      idle_inputs(1'b0);
      vectors++;
      if (acks !== 1) begin
         miscompares++; $display("FAIL held_req_rearm: acks=%0d required 1", acks);
      end
      @(negedge clk);
   endtask

   task automatic test_drop_mid();
      obs_t o;
      int t;
      t = -1;
      bus.cpu_req = 1; bus.cpu_oe = 0; bus.cpu_we = 1; bus.cpu_addr = 23'h000021; bus.cpu_dati = 8'h77;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 2) bus.cpu_req = 0;
         if (bus.cpu_ack) begin t = k; break; end
      end
      idle_inputs(1'b0);
      ref_mem[10'h010][15:8] = 8'h77;
      vectors++;
      if (t !== 5) begin
         miscompares++; $display("FAIL drop_mid_ack: ack@%0d required 5", t);
      end
      @(negedge clk);
      run_access(1'b0, 1'b1, 1'b0, 23'h000021, 16'h0, o);
      vectors++;
      if (o.rd[7:0] !== 8'h77 || o.lat !== 5) begin
         miscompares++; $display("FAIL drop_mid_readback: data=%h lat=%0d required 77/5", o.rd[7:0], o.lat);
      end
   endtask

   task automatic test_mid_reset();
      int acks, t;
      acks = 0; t = -1;
      bus.dma_req = 1; bus.dma_oe = 0; bus.dma_we = 1; bus.dma_addr = 23'h0007FE; bus.dma_dati = 16'hCAFE;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (bus.dma_ack) acks++;
      end
      rst = 1'b1; bus.dma_req = 0;
      @(negedge clk);
      if (bus.dma_ack) acks++;
      vectors++;
      if ({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n, bus.ram_dq_oe} !== 6'b111110) begin
         miscompares++;
         $display("FAIL mid_reset_pins: ce/oe/we/ub/lb/dq_oe=%b required 111110",
                  {bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n, bus.ram_dq_oe});
      end
      vectors++;
      if (bus.dma_dato !== 16'h0000 || bus.ram_addr !== 22'h0) begin
         miscompares++; $display("FAIL mid_reset_regs: dma_dato=%h addr=%h required 0/0", bus.dma_dato, bus.ram_addr);
      end
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.dma_ack || !bus.ram_ce_n) acks++;
      end
      vectors++;
      if (acks !== 0) begin
         miscompares++; $display("FAIL mid_reset_quiet: %0d ack/active cycles required 0", acks);
      end
      bus.dma_req = 1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.dma_ack) begin t = k; break; end
      end
      idle_inputs(1'b1);
      ref_mem[10'h3FF] = 16'hCAFE;
      vectors++;
      if (t !== 5) begin
         miscompares++; $display("FAIL mid_reset_rearm: ack@%0d required 5", t);
      end
      @(negedge clk);
   endtask

   task automatic test_wait_extremes();
      for (int pass = 0; pass < 4; pass++) begin
         bit dma;
         int t1, t15;
         logic [22:0] addr;
         logic [15:0] r1, r15, exp;
         dma  = (pass >= 2);
         addr = 23'($urandom_range(0, 8191));
         exp  = dma ? pat(addr[22:1]) : {8'h00, addr[0] ? pat(addr[22:1])[15:8] : pat(addr[22:1])[7:0]};
         t1 = -1; t15 = -1; r1 = '0; r15 = '0;
         if (dma) begin
            bus1.dma_req = 1; bus1.dma_oe = 1; bus1.dma_addr = addr;
            bus15.dma_req = 1; bus15.dma_oe = 1; bus15.dma_addr = addr;
         end else begin
            bus1.cpu_req = 1; bus1.cpu_oe = 1; bus1.cpu_addr = addr;
            bus15.cpu_req = 1; bus15.cpu_oe = 1; bus15.cpu_addr = addr;
         end
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((dma ? bus1.dma_ack : bus1.cpu_ack) && t1 < 0) begin
               t1 = k; r1 = dma ? bus1.dma_dato : {8'h00, bus1.cpu_dato};
               bus1.cpu_req = 0; bus1.dma_req = 0;
            end
            if ((dma ? bus15.dma_ack : bus15.cpu_ack) && t15 < 0) begin
               t15 = k; r15 = dma ? bus15.dma_dato : {8'h00, bus15.cpu_dato};
               bus15.cpu_req = 0; bus15.dma_req = 0;
            end
            if (t1 >= 0 && t15 >= 0) break;
         end
         bus1.cpu_req = 0; bus1.dma_req = 0; bus15.cpu_req = 0; bus15.dma_req = 0;
         @(negedge clk);
         vectors++;
         if (t1 !== 3 || r1 !== exp) begin
            miscompares++; $display("FAIL wait1_pass%0d: lat=%0d data=%h required 3/%h", pass, t1, r1, exp);
         end
         vectors++;
         if (t15 !== 17 || r15 !== exp) begin
            miscompares++; $display("FAIL wait15_pass%0d: lat=%0d data=%h required 17/%h", pass, t15, r15, exp);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_arbitration();
      test_held_req();
      test_drop_mid();
      test_random();
      test_mid_reset();
      test_wait_extremes();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
